qspi_arbiter: RTL and testbench
===============================

QSPI_ARBITER -- requirements
Module: qspi_arbiter

Interface
REQ-001 Parameter CS_GAP, default 2: idle cycles with all chip selects high between transactions (PSRAM tCPH); range 0..15.
REQ-002 Parameter MAX_STREAK, default 4: consecutive data grants allowed while an instruction request waits.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: active-transaction limit, used only when QSPI_ARB_TIMEOUT_EN is defined.
REQ-004 The block has one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  system clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 instr_req, data_req  in  1 each  requests, held high until the matching done pulse.
REQ-008 instr_sel, data_sel  in  2 each  target: 0 flash, 1 RAM A, 2 RAM B, 3 invalid.
REQ-009 instr_gnt, data_gnt  out  1 each  high while that requester owns the bus.
REQ-010 instr_done, data_done  out  1 each  one-cycle completion pulse.
REQ-011 err  out  1  valid with a done pulse; 1 means rejected or aborted.
REQ-012 ctl_start  out  1  one-cycle start pulse to the QSPI controller.
REQ-013 ctl_sel  out  2  target of the current transaction.
REQ-014 ctl_done  in  1  controller completion pulse.
REQ-015 ctl_abort  out  1  one-cycle abort pulse to the controller.
REQ-016 cs_n  out  3  {ram_b, ram_a, flash} chip selects, active low, at most one low.

Function
REQ-017 The FSM SHALL have four states: IDLE, GRANT, ACTIVE and GAP.
REQ-018 IDLE: if any request is sampled high, the arbiter SHALL latch the winner and sel and enter GRANT on the next cycle.
REQ-019 Arbitration SHALL favour data over instruction, except that instruction wins when streak==MAX_STREAK and instr_req is high.
REQ-020 The streak counter SHALL increment on each data grant made while instr_req is high, reset on any instruction grant, and saturate at MAX_STREAK.
REQ-021 GRANT (one cycle): gnt SHALL assert, ctl_start SHALL pulse and the decoded cs_n bit SHALL go low; then the FSM enters ACTIVE; gnt and cs_n hold through ACTIVE.
REQ-022 A grant with sel==3 SHALL produce no ctl_start and no CS; done and err SHALL pulse in the GRANT cycle; then the FSM enters GAP.
REQ-023 ACTIVE plus ctl_done: next cycle gnt drops, cs_n all high, done pulses with err=0, and the FSM enters GAP (IDLE if CS_GAP==0).
REQ-024 GAP SHALL hold cs_n all high for exactly CS_GAP cycles, then return to IDLE.
REQ-025 Request deassertion during GRANT, ACTIVE or GAP SHALL be ignored, and the transaction SHALL complete.
REQ-026 Minimum request-to-start latency SHALL be 1 cycle.
REQ-027 ctl_done outside ACTIVE SHALL be ignored.

Reset
REQ-028 On asynchronous reset assertion, cs_n SHALL go to 3'b111 immediately.
REQ-029 Reset SHALL clear all gnt/done/err/ctl_start/ctl_abort outputs and set ctl_sel=0, streak=0, state=IDLE, including mid-transaction.

Configuration
REQ-030 With QSPI_ARB_TIMEOUT_EN defined, an ACTIVE cycle counter SHALL be present.
REQ-031 With QSPI_ARB_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL pulse ctl_abort, raise cs_n, pulse done with err=1 and enter GAP.
REQ-032 With QSPI_ARB_TIMEOUT_EN defined, if ctl_done and timeout occur in the same cycle, done SHALL win with err=0.
REQ-033 Without QSPI_ARB_TIMEOUT_EN, the counter SHALL be absent, ctl_abort SHALL be tied 0 and ACTIVE SHALL wait indefinitely.

Structure
REQ-034 Package qspi_arb_pkg SHALL hold the target enum, the FSM state enum and the one-hot CS decode constants.
REQ-035 Sub-module qspi_arb_pick SHALL contain the combinational winner selection, including the streak rule.

Verification
REQ-036 data_req=1 sel=1 in IDLE -> next cycle data_gnt=1, ctl_start pulse, cs_n=3'b101; ctl_done -> data_done next cycle, then cs_n=111 for 2 cycles.
REQ-037 Both requesters held continuously, each done followed by a new request -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-038 instr_req sel=3 -> no ctl_start, cs_n=111, instr_done=1 with err=1 in the GRANT cycle.
REQ-039 rst_n low in the 3rd ACTIVE cycle -> cs_n=111 immediately, all outputs cleared; a request after release is granted normally.
REQ-040 With QSPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ctl_done -> ctl_abort and done with err=1 after 8 ACTIVE cycles; ctl_done on cycle 8 -> err=0.
REQ-041 With CS_GAP=0, back-to-back requests -> next GRANT one cycle after the done pulse.

Source files
------------

// File: rtl/qspi_arb_pkg.sv
// Shared types for the QSPI bus arbiter: target select, FSM states and chip-select decode.
package qspi_arb_pkg;

  typedef enum logic [1:0] {
    TGT_FLASH   = 2'd0,
    TGT_RAM_A   = 2'd1,
    TGT_RAM_B   = 2'd2,
    TGT_INVALID = 2'd3
  } tgt_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  // cs_n bit order is {ram_b, ram_a, flash}, active low
  localparam logic [2:0] CS_NONE  = 3'b111;
  localparam logic [2:0] CS_FLASH = 3'b110;
  localparam logic [2:0] CS_RAM_A = 3'b101;
  localparam logic [2:0] CS_RAM_B = 3'b011;

  function automatic logic [2:0] cs_decode(input tgt_e t);
    case (t)
      TGT_FLASH: cs_decode = CS_FLASH;
      TGT_RAM_A: cs_decode = CS_RAM_A;
      TGT_RAM_B: cs_decode = CS_RAM_B;
      default:   cs_decode = CS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/qspi_arb_pick.sv
// Winner selection: data has priority unless the instruction side has waited out MAX_STREAK data grants.
module qspi_arb_pick #(
  parameter int MAX_STREAK = 4,
  parameter int SW         = 3
) (
  input  logic          i_instr_req,
  input  logic          i_data_req,
  input  logic [SW-1:0] i_streak,
  output logic          o_pick_instr,
  output logic          o_pick_any
);

  logic w_sat;

  assign w_sat        = (i_streak == SW'(MAX_STREAK));
  assign o_pick_any   = i_instr_req | i_data_req;
  assign o_pick_instr = i_instr_req & (~i_data_req | w_sat);

endmodule

// File: rtl/qspi_arbiter.sv
// Two-requester QSPI bus arbiter with chip-select gap timing.
// Optional ACTIVE watchdog enabled by defining QSPI_ARB_TIMEOUT_EN.
module qspi_arbiter
  import qspi_arb_pkg::*;
#(
  parameter int CS_GAP         = 2,
  parameter int MAX_STREAK     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_req,
  input  logic [1:0] instr_sel,
  input  logic       data_req,
  input  logic [1:0] data_sel,
  output logic       instr_gnt,
  output logic       data_gnt,
  output logic       instr_done,
  output logic       data_done,
  output logic       err,
  output logic       ctl_start,
  output logic [1:0] ctl_sel,
  input  logic       ctl_done,
  output logic       ctl_abort,
  output logic [2:0] cs_n
);

  localparam int     SW         = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam state_e AFTER_DONE = (CS_GAP == 0) ? ST_IDLE : ST_GAP;

  state_e        r_state, w_state_nxt;
  tgt_e          r_sel;
  logic          r_own_instr;
  logic [SW-1:0] r_streak;
  logic [3:0]    r_gap_cnt;
  logic          r_done, r_err;
  logic          w_pick_instr, w_pick_any;
  logic          w_latch, w_end, w_end_err, w_gap_load;
  logic          w_timeout, w_invalid, w_busy, w_inv_done, w_done;

  qspi_arb_pick #(.MAX_STREAK(MAX_STREAK), .SW(SW)) u_pick (
    .i_instr_req (instr_req),
    .i_data_req  (data_req),
    .i_streak    (r_streak),
    .o_pick_instr(w_pick_instr),
    .o_pick_any  (w_pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_end       = 1'b0;
    w_end_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT:  w_state_nxt = w_invalid ? AFTER_DONE : ST_ACTIVE;
      ST_ACTIVE: begin
        // completion takes precedence over a coincident timeout
        if (ctl_done) begin
          w_end       = 1'b1;
          w_state_nxt = AFTER_DONE;
        end else if (w_timeout) begin
          w_end       = 1'b1;
          w_end_err   = 1'b1;
          w_state_nxt = AFTER_DONE;
        end
      end
      ST_GAP:  if (r_gap_cnt == 4'd0) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    w_gap_load = (w_state_nxt == ST_GAP) && (r_state != ST_GAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel       <= TGT_FLASH;
      r_own_instr <= 1'b0;
      r_streak    <= '0;
      r_gap_cnt   <= 4'd0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= w_end;
      r_err  <= w_end_err;
      if (w_latch) begin
        r_own_instr <= w_pick_instr;
        r_sel       <= w_pick_instr ? tgt_e'(instr_sel) : tgt_e'(data_sel);
        if (w_pick_instr)
          r_streak <= '0;
        else if (instr_req && (r_streak != SW'(MAX_STREAK)))
          r_streak <= r_streak + 1'b1;
      end
      if (w_gap_load)
        r_gap_cnt <= 4'(CS_GAP - 1);
      else if ((r_state == ST_GAP) && (r_gap_cnt != 4'd0))
        r_gap_cnt <= r_gap_cnt - 1'b1;
    end
  end

`ifdef QSPI_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] r_to_cnt;
  logic          r_abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
      r_abort  <= 1'b0;
    end else begin
      r_abort <= w_end_err;
      if (r_state == ST_GRANT)
        r_to_cnt <= TW'(TIMEOUT_CYCLES - 1);
      else if ((r_state == ST_ACTIVE) && (r_to_cnt != '0))
        r_to_cnt <= r_to_cnt - 1'b1;
    end
  end

  assign w_timeout = (r_to_cnt == '0);
  assign ctl_abort = r_abort;
`else
  assign w_timeout = 1'b0;
  assign ctl_abort = 1'b0;
`endif

  assign w_invalid  = (r_sel == TGT_INVALID);
  assign w_busy     = (r_state == ST_GRANT) || (r_state == ST_ACTIVE);
  assign w_inv_done = (r_state == ST_GRANT) && w_invalid;
  assign w_done     = r_done | w_inv_done;

  assign instr_gnt  = w_busy & r_own_instr;
  assign data_gnt   = w_busy & ~r_own_instr;
  assign instr_done = w_done & r_own_instr;
  assign data_done  = w_done & ~r_own_instr;
  assign err        = r_err | w_inv_done;
  assign ctl_start  = (r_state == ST_GRANT) && !w_invalid;
  assign ctl_sel    = r_sel;
  assign cs_n       = (w_busy && !w_invalid) ? cs_decode(r_sel) : CS_NONE;

endmodule

// File: tb/tb_qspi_arbiter.sv
// Directed bench for qspi_arbiter: a CS_GAP=2 instance for the main sequence and a CS_GAP=0 instance.
module tb_qspi_arbiter;

  logic       clk, rst_n;
  logic       instr_req, data_req, ctl_done;
  logic [1:0] instr_sel, data_sel, ctl_sel;
  logic       instr_gnt, data_gnt, instr_done, data_done, err, ctl_start, ctl_abort;
  logic [2:0] cs_n;

  logic       z_instr_req, z_data_req, z_ctl_done;
  logic [1:0] z_instr_sel, z_data_sel, z_ctl_sel;
  logic       z_instr_gnt, z_data_gnt, z_instr_done, z_data_done, z_err, z_ctl_start, z_ctl_abort;
  logic [2:0] z_cs_n;

  int n_chk = 0;
  int n_fail = 0;

  qspi_arbiter #(.CS_GAP(2), .MAX_STREAK(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req(instr_req), .instr_sel(instr_sel),
    .data_req(data_req), .data_sel(data_sel),
    .instr_gnt(instr_gnt), .data_gnt(data_gnt),
    .instr_done(instr_done), .data_done(data_done), .err(err),
    .ctl_start(ctl_start), .ctl_sel(ctl_sel), .ctl_done(ctl_done),
    .ctl_abort(ctl_abort), .cs_n(cs_n)
  );

  qspi_arbiter #(.CS_GAP(0), .MAX_STREAK(4), .TIMEOUT_CYCLES(8)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .instr_req(z_instr_req), .instr_sel(z_instr_sel),
    .data_req(z_data_req), .data_sel(z_data_sel),
    .instr_gnt(z_instr_gnt), .data_gnt(z_data_gnt),
    .instr_done(z_instr_done), .data_done(z_data_done), .err(z_err),
    .ctl_start(z_ctl_start), .ctl_sel(z_ctl_sel), .ctl_done(z_ctl_done),
    .ctl_abort(z_ctl_abort), .cs_n(z_cs_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [9:0] exp_data;
    logic       found, seen;

    rst_n = 1'b0;
    instr_req = 1'b0; instr_sel = 2'd0; data_req = 1'b0; data_sel = 2'd0; ctl_done = 1'b0;
    z_instr_req = 1'b0; z_instr_sel = 2'd0; z_data_req = 1'b0; z_data_sel = 2'd0; z_ctl_done = 1'b0;
    #3;
    chk("rst_cs_n", 32'(cs_n), 32'h7);
    chk("rst_outs", {25'd0, instr_gnt, data_gnt, instr_done, data_done, err, ctl_start, ctl_abort}, 32'h0);
    chk("rst_ctl_sel", 32'(ctl_sel), 32'h0);
    #14 rst_n = 1'b1;
    tick();

    // single data transaction to RAM A
    data_req = 1'b1; data_sel = 2'd1;
    tick();
    chk("d1_gnt", {30'd0, instr_gnt, data_gnt}, 32'h1);
    chk("d1_start", 32'(ctl_start), 32'h1);
    chk("d1_cs_n", 32'(cs_n), 32'h5);
    chk("d1_ctl_sel", 32'(ctl_sel), 32'h1);
    tick();
    chk("d1_active", {29'd0, ctl_start, cs_n == 3'b101, data_gnt}, 32'h3);
    ctl_done = 1'b1;
    tick();
    ctl_done = 1'b0;
    chk("d1_done", {29'd0, data_done, err, data_gnt}, 32'h4);
    chk("d1_gap1_cs", 32'(cs_n), 32'h7);
    data_req = 1'b0;
    tick();
    chk("d1_gap2", {28'd0, cs_n, data_done}, 32'he);
    tick();

    // streak rule with both requesters held
    exp_data = 10'b0111101111;
    instr_req = 1'b1; instr_sel = 2'd0; data_req = 1'b1; data_sel = 2'd2;
    for (int k = 0; k < 10; k++) begin
      found = 1'b0;
      for (int t = 0; t < 10; t++) begin
        tick();
        if (instr_gnt || data_gnt) begin
          found = 1'b1;
          break;
        end
      end
      chk($sformatf("str%0d_found", k), 32'(found), 32'h1);
      chk($sformatf("str%0d_owner", k), 32'(data_gnt), 32'(exp_data[k]));
      chk($sformatf("str%0d_cs", k), 32'(cs_n), exp_data[k] ? 32'h3 : 32'h6);
      tick();
      ctl_done = 1'b1;
      tick();
      ctl_done = 1'b0;
      chk($sformatf("str%0d_done", k), {30'd0, instr_done, data_done},
          exp_data[k] ? 32'h1 : 32'h2);
      if (k == 9) begin
        instr_req = 1'b0; data_req = 1'b0;
      end
    end

    // invalid target rejected in the grant cycle
    instr_req = 1'b1; instr_sel = 2'd3;
    found = 1'b0; seen = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (ctl_start) seen = 1'b1;
      if (instr_done) begin
        found = 1'b1;
        break;
      end
    end
    chk("inv_done", 32'(found), 32'h1);
    chk("inv_no_start", 32'(seen), 32'h0);
    chk("inv_cs_err", {28'd0, cs_n, err}, 32'hf);
    instr_req = 1'b0;
    tick();
    chk("inv_one_pulse", {30'd0, instr_done, err}, 32'h0);
    tick();
    tick();

    // stray ctl_done in IDLE
    ctl_done = 1'b1;
    tick();
    ctl_done = 1'b0;
    chk("stray_done", {28'd0, instr_done, data_done, err, data_gnt}, 32'h0);

    // reset in the third ACTIVE cycle
    data_req = 1'b1; data_sel = 2'd0;
    tick(); tick(); tick(); tick();
    chk("rst_pre_cs", 32'(cs_n), 32'h6);
    #2 rst_n = 1'b0;
    data_sel = 2'd1;
    #1;
    chk("rst_mid_cs", 32'(cs_n), 32'h7);
    chk("rst_mid_outs", {25'd0, instr_gnt, data_gnt, instr_done, data_done, err, ctl_start, ctl_abort}, 32'h0);
    chk("rst_mid_sel", 32'(ctl_sel), 32'h0);
    #3 rst_n = 1'b1;
    tick();
    chk("post_rst_gnt", {28'd0, data_gnt, ctl_start, ctl_sel}, 32'hd);
    chk("post_rst_cs", 32'(cs_n), 32'h5);
    tick();
    ctl_done = 1'b1;
    tick();
    ctl_done = 1'b0;
    chk("post_rst_done", {30'd0, data_done, err}, 32'h2);
    data_req = 1'b0;
    tick(); tick();

`ifdef QSPI_ARB_TIMEOUT_EN
    data_req = 1'b1; data_sel = 2'd2;
    tick();
    for (int t = 0; t < 8; t++) tick();
    chk("to_act8", {30'd0, data_gnt, ctl_abort}, 32'h2);
    tick();
    chk("to_abort", {26'd0, ctl_abort, data_done, err, cs_n}, 32'h3f);
    data_req = 1'b0;
    tick();
    chk("to_abort_pulse", 32'(ctl_abort), 32'h0);
    tick();
    data_req = 1'b1;
    tick();
    for (int t = 0; t < 8; t++) tick();
    ctl_done = 1'b1;
    tick();
    ctl_done = 1'b0;
    chk("to_race", {29'd0, ctl_abort, data_done, err}, 32'h2);
    data_req = 1'b0;
    tick(); tick();
`else
    data_req = 1'b1; data_sel = 2'd2;
    tick();
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (ctl_abort || !data_gnt) seen = 1'b1;
    end
    chk("no_to_wait", 32'(seen), 32'h0);
    ctl_done = 1'b1;
    tick();
    ctl_done = 1'b0;
    chk("no_to_done", {29'd0, ctl_abort, data_done, err}, 32'h2);
    data_req = 1'b0;
    tick(); tick();
`endif

    // CS_GAP=0: next grant one cycle after done
    z_data_req = 1'b1; z_data_sel = 2'd1;
    found = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (z_data_gnt) begin
        found = 1'b1;
        break;
      end
    end
    chk("g0_found", 32'(found), 32'h1);
    tick();
    z_ctl_done = 1'b1;
    tick();
    z_ctl_done = 1'b0;
    chk("g0_done", {28'd0, z_data_done, z_cs_n}, 32'hf);
    tick();
    chk("g0_regrant", {28'd0, z_data_gnt, z_ctl_start, z_ctl_sel}, 32'hd);
    z_data_req = 1'b0;
    tick();
    z_ctl_done = 1'b1;
    tick();
    z_ctl_done = 1'b0;
    chk("g0_done2", 32'(z_data_done), 32'h1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
